// File: rtl/bar_hold_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bar_hold_scheduler_if
//  Description : Requester/scheduler signal bundle for the shared bar signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bar_hold_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_val;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            foo;
    logic            bar;
    logic            bar_steady;

    modport master (
        output req, req_val,
        input  gnt, done, foo, bar, bar_steady
    );

    modport slave (
        input  req, req_val,
        output gnt, done, foo, bar, bar_steady
    );
endinterface
`default_nettype wire

// File: rtl/bar_hold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bar_hold_scheduler
//  Description : Round-robin owner of the shared bar signal; holds the granted
//                value for HOLD_CYCLES with a GAP_CYCLES guard between owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module bar_hold_scheduler #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bar_hold_scheduler_if.slave bus
);

    localparam int c_PW  = $clog2(NREQ);
    localparam int c_PW1 = c_PW + 1;
    localparam int c_HW  = $clog2(HOLD_CYCLES + 1);
    localparam int c_GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(HOLD_CYCLES - 1);
    localparam logic [c_GW-1:0] c_GAP_LOAD  = (GAP_CYCLES > 0) ? c_GW'(GAP_CYCLES - 1) : '0;
    localparam logic [c_PW-1:0] c_LAST      = c_PW'(NREQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]      r_state;
    logic [c_PW-1:0] r_rr_ptr;
    logic [c_HW-1:0] r_hold_cnt;
    logic [c_GW-1:0] r_gap_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_foo;
    logic            r_bar;
    logic            r_bar_steady;

    logic            w_any;
    logic [c_PW-1:0] w_pick;
    logic [c_PW:0]   w_sum;
    logic [c_PW-1:0] w_idx;
    logic [NREQ-1:0] w_onehot;
    logic [c_PW-1:0] w_next_ptr;
    logic            w_start;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + c_PW1'(k);
            if (w_sum >= c_PW1'(NREQ)) begin
                w_sum = w_sum - c_PW1'(NREQ);
            end
            w_idx = w_sum[c_PW-1:0];
            if (bus.req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot   = NREQ'(1) << w_pick;
        w_next_ptr = (w_pick == c_LAST) ? '0 : w_pick + c_PW'(1);
        // The last guard cycle (or last HOLD cycle with no guard) may grant directly.
        w_start    = w_any && ((r_state == S_IDLE) ||
                               (r_state == S_GAP  && r_gap_cnt == '0) ||
                               (r_state == S_HOLD && r_hold_cnt == '0 && GAP_CYCLES == 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_foo        <= 1'b0;
            r_bar        <= 1'b0;
            r_bar_steady <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                end
                S_SETUP: begin
                    r_state      <= S_HOLD;
                    r_bar_steady <= 1'b1;
                    r_hold_cnt   <= c_HOLD_LOAD;
                    if (HOLD_CYCLES == 1) begin
                        r_done <= r_gnt;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - c_HW'(1);
                        if (r_hold_cnt == c_HW'(1)) begin
                            r_done <= r_gnt;
                        end
                    end else begin
                        r_foo        <= 1'b0;
                        r_gnt        <= '0;
                        r_bar_steady <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= c_GAP_LOAD;
                        end
                    end
                end
                default: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - c_GW'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            if (w_start) begin
                r_state  <= S_SETUP;
                r_gnt    <= w_onehot;
                r_bar    <= bus.req_val[w_pick];
                r_foo    <= 1'b1;
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.done       = r_done;
    assign bus.foo        = r_foo;
    assign bus.bar        = r_bar;
    assign bus.bar_steady = r_bar_steady;

endmodule
`default_nettype wire

// File: tb/tb_bar_hold_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bar_hold_scheduler
//  Description : Bench for bar_hold_scheduler in a 4/4/1 and a 2/1/0 setup.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bar_hold_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n   = 0;
    int   checks = 0;
    int   errors = 0;

    bar_hold_scheduler_if #(.NREQ(4)) ifa ();
    bar_hold_scheduler_if #(.NREQ(2)) ifb ();

    bar_hold_scheduler #(.NREQ(4), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bar_hold_scheduler #(.NREQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    // Transaction-level view: who owns bar and since which edge.
    typedef struct {
        bit has;
        int t0;
        int idx;
        bit bar;
        int ptr;
    } mdl_t;

    mdl_t ma, mb;
    int   ga_n[$], ga_i[$], gb_n[$], gb_i[$];
    logic [3:0] prev_gnt_a;
    logic [1:0] prev_gnt_b;
    logic prev_st_a, prev_bar_a, prev_st_b, prev_bar_b;

    function automatic mdl_t mstep(mdl_t m, int e, bit rs, logic [3:0] rq, logic [3:0] vl,
                                   int nreq, int h, int g);
        mdl_t r = m;
        if (rs) begin
            r.has = 0; r.t0 = 0; r.idx = 0; r.bar = 0; r.ptr = 0;
            return r;
        end
        if (!m.has || e >= m.t0 + h + g + 1) begin
            for (int k = 0; k < nreq; k++) begin
                int j = (m.ptr + k) % nreq;
                if (rq[j]) begin
                    r.has = 1; r.t0 = e; r.idx = j; r.bar = vl[j]; r.ptr = (j + 1) % nreq;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Packed as {gnt[3:0], done[3:0], foo, bar, bar_steady}.
    function automatic logic [10:0] mexp(mdl_t m, int e, int h);
        int   d   = e - m.t0;
        logic act = m.has && d <= h;
        logic [3:0] oh = 4'(1) << m.idx;
        return {act ? oh : 4'd0, (m.has && d == h) ? oh : 4'd0, act, m.bar, act && d >= 1};
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        logic [3:0]  ra = ifa.req, va = ifa.req_val;
        logic [3:0]  rb = {2'b00, ifb.req}, vb = {2'b00, ifb.req_val};
        bit          rs = rst;
        logic [10:0] ea, eb;
        @(posedge clk);
        n++;
        ma = mstep(ma, n, rs, ra, va, 4, 4, 1);
        mb = mstep(mb, n, rs, rb, vb, 2, 1, 0);
        #1;
        ea = mexp(ma, n, 4);
        eb = mexp(mb, n, 1);
        chk("A.gnt",  32'(ifa.gnt),        32'(ea[10:7]));
        chk("A.done", 32'(ifa.done),       32'(ea[6:3]));
        chk("A.foo",  32'(ifa.foo),        32'(ea[2]));
        chk("A.bar",  32'(ifa.bar),        32'(ea[1]));
        chk("A.bar_steady", 32'(ifa.bar_steady), 32'(ea[0]));
        chk("B.gnt",  32'(ifb.gnt),        32'(eb[8:7]));
        chk("B.done", 32'(ifb.done),       32'(eb[4:3]));
        chk("B.foo",  32'(ifb.foo),        32'(eb[2]));
        chk("B.bar",  32'(ifb.bar),        32'(eb[1]));
        chk("B.bar_steady", 32'(ifb.bar_steady), 32'(eb[0]));
        chk("A.gnt_onehot0", 32'($onehot0(ifa.gnt)), 32'd1);
        chk("A.done_onehot0", 32'($onehot0(ifa.done)), 32'd1);
        if (ifa.done != 0)     chk("A.done_needs_steady", 32'(ifa.bar_steady), 32'd1);
        if (ifa.bar_steady)    chk("A.steady_needs_foo", 32'(ifa.foo), 32'd1);
        if (prev_st_a && ifa.bar_steady) chk("A.bar_stable", 32'(ifa.bar), 32'(prev_bar_a));
        if (prev_st_b && ifb.bar_steady) chk("B.bar_stable", 32'(ifb.bar), 32'(prev_bar_b));
        if (ifa.gnt != 0 && ifa.gnt != prev_gnt_a) begin
            ga_n.push_back(n); ga_i.push_back(oh_idx(ifa.gnt));
        end
        if (ifb.gnt != 0 && ifb.gnt != prev_gnt_b) begin
            gb_n.push_back(n); gb_i.push_back(oh_idx({2'b00, ifb.gnt}));
        end
        prev_gnt_a = ifa.gnt;  prev_gnt_b = ifb.gnt;
        prev_st_a  = ifa.bar_steady; prev_bar_a = ifa.bar;
        prev_st_b  = ifb.bar_steady; prev_bar_b = ifb.bar;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ga_n.delete(); ga_i.delete(); gb_n.delete(); gb_i.delete();
    endtask

    initial begin
        int steady_cnt, done_at, k;
        logic held_bar;
        ifa.req = '0; ifa.req_val = '0; ifb.req = '0; ifb.req_val = '0;
        ma = '{default: 0}; mb = '{default: 0};
        prev_gnt_a = '0; prev_gnt_b = '0;
        prev_st_a = 0; prev_bar_a = 0; prev_st_b = 0; prev_bar_b = 0;

        do_reset();
        chk("reset.outputs_A", 32'({ifa.gnt, ifa.done, ifa.foo, ifa.bar, ifa.bar_steady}), 32'd0);
        chk("reset.outputs_B", 32'({ifb.gnt, ifb.done, ifb.foo, ifb.bar, ifb.bar_steady}), 32'd0);

        // Single requester 2 with value 1.
        ifa.req = 4'b0100; ifa.req_val = 4'b0100;
        tick();
        chk("single.gnt", 32'(ifa.gnt), 32'h4);
        chk("single.foo_bar_steady", 32'({ifa.foo, ifa.bar, ifa.bar_steady}), 32'b110);
        ifa.req = '0;
        steady_cnt = 0; done_at = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            steady_cnt += int'(ifa.bar_steady);
            if (ifa.done == 4'b0100) done_at = i;
        end
        chk("single.steady_cycles", 32'(steady_cnt), 32'd4);
        chk("single.done_cycle", 32'(done_at), 32'd4);
        tick();
        chk("single.gap_foo_gnt", 32'({ifa.foo, ifa.gnt}), 32'd0);
        tick();

        // Round-robin with all requesting.
        do_reset();
        ifa.req = 4'b1111; ifa.req_val = 4'b1010;
        for (int i = 0; i < 27; i++) tick();
        chk("rr.grant_count_ge5", 32'(ga_i.size() >= 5), 32'd1);
        if (ga_i.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr.order", 32'(ga_i[i]), 32'(i % 4));
            for (int i = 1; i < 5; i++) chk("rr.spacing", 32'(ga_n[i] - ga_n[i-1]), 32'd6);
        end

        // Stability while inputs churn during HOLD.
        do_reset();
        ifa.req = 4'b0010; ifa.req_val = 4'($urandom);
        held_bar = ifa.req_val[1];
        tick();
        steady_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ifa.req = (i % 2 == 0) ? 4'b0000 : 4'b1101;
            ifa.req_val = ~ifa.req_val;
            tick();
            steady_cnt += int'(ifa.bar_steady);
            if (i < 4) begin
                chk("stable.bar", 32'(ifa.bar), 32'(held_bar));
                chk("stable.gnt", 32'(ifa.gnt), 32'h2);
            end
        end
        chk("stable.steady_cycles", 32'(steady_cnt), 32'd4);

        // Reset in the second HOLD cycle.
        do_reset();
        ifa.req = 4'b0001; ifa.req_val = 4'b0001;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset.outputs", 32'({ifa.gnt, ifa.done, ifa.foo, ifa.bar, ifa.bar_steady}), 32'd0);
        ifa.req = 4'b0011;
        tick();
        chk("midreset.ptr0_grant", 32'(ifa.gnt), 32'h1);

        // Pointer wrap from 3 back to 0.
        do_reset();
        ifa.req = 4'b0100; ifa.req_val = 4'b0000;
        tick();
        ifa.req = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        ifa.req = 4'b0011;
        tick();
        chk("wrap.grant0", 32'(ifa.gnt), 32'h1);
        for (int i = 0; i < 6; i++) tick();
        chk("wrap.then_grant1", 32'(ifa.gnt), 32'h2);

        // No-guard configuration, back-to-back.
        do_reset();
        ifa.req = '0;
        ifb.req = 2'b11; ifb.req_val = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        chk("b2b.grant_count_ge5", 32'(gb_i.size() >= 5), 32'd1);
        if (gb_i.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("b2b.order", 32'(gb_i[i]), 32'(i % 2));
            for (int i = 1; i < 5; i++) chk("b2b.spacing", 32'(gb_n[i] - gb_n[i-1]), 32'd2);
        end
        ifb.req = '0;

        // Random traffic on both instances.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            k = int'($urandom_range(0, 99));
            rst = (k == 0);
            ifa.req = 4'($urandom); ifa.req_val = 4'($urandom);
            ifb.req = 2'($urandom); ifb.req_val = 2'($urandom);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
